// File: rtl/sdpram_stream_reader.sv
// Burst read controller for the registered 64x32 simple-dual-port RAM (port B):
// issues credit-limited reads, tracks the fixed read latency, and streams words out.
module sdpram_stream_reader #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic                fifo_last_q [FIFO_DEPTH];

  logic                issue;
  logic                last_tag;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  logic [CNT_W:0]      credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits are registered-only: a pop in the same cycle does not free a slot.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign issue       = (state_q == S_ISSUE) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign last_tag    = (remaining_q == (ADDR_W + 1)'(1));
  assign push        = pipe_vld_q[RD_LATENCY-1];
  assign fifo_empty  = (count_q == '0);
  // Stream: a beat transfers on a rising edge where m_valid & m_ready; m_data/m_last
  // are held while m_valid & !m_ready, and m_valid never drops without a transfer.
  assign pop         = !fifo_empty && m_ready;

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rd_en       = issue;
  assign rd_addr     = cur_addr_q;
  assign m_valid     = !fifo_empty;
  assign m_data      = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
  assign m_last      = fifo_empty ? 1'b0 : fifo_last_q[rd_ptr_q];
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && (cmd_len != '0)) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W + 1)'(1);
          if (last_tag) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && m_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !push)      inflight_d = inflight_q + CNT_W'(1);
    else if (!issue && push) inflight_d = inflight_q - CNT_W'(1);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    pipe_vld_d     = '0;
    pipe_last_d    = '0;
    pipe_vld_d[0]  = issue;
    pipe_last_d[0] = issue && last_tag;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q and the outputs are gated.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LATENCY-1];
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) push |-> (count_q < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_sdpram_stream_reader.sv
// Bench for sdpram_stream_reader: registered RAM model, burst vector table,
// random bursts against a queue-based reference, and reset/corner sequences.
module tb_sdpram_stream_reader;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [1:0]    dbg_state;

  sdpram_stream_reader #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM wrapper model: read data appears LAT edges after rd_en is sampled
  logic [DW-1:0] ram [64];
  logic [DW-1:0] rpipe [LAT];
  logic          en_s = 1'b0;
  logic [AW-1:0] addr_s = '0;

  always @(negedge clk) begin
    en_s   <= rd_en;
    addr_s <= rd_addr;
  end

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    rpipe[0] <= en_s ? ram[addr_s] : $urandom;
  end
  assign rd_data = rpipe[LAT-1];

  // ---------------- consumer ----------------
  int ready_pct = 100;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            tot_issues = 0;
  int            tot_beats  = 0;
  int            outstanding = 0;
  int            acc_edge = 0;
  int            hs_edge [int];
  logic [DW-1:0] last_word = '0;
  logic          held_v = 1'b0;
  logic [DW:0]   held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_addr_q.delete();
      outstanding = 0;
      held_v      = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_edge = cyc + 1;
        for (int i = 0; i < int'(cmd_len); i++) begin
          int a;
          a = (int'(cmd_addr) + i) % 64;
          exp_addr_q.push_back(AW'(a));
          exp_q.push_back({(i == int'(cmd_len) - 1), ram[a]});
        end
      end
      if (rd_en) begin
        chk("credit_limit", (outstanding < DEPTH), 1'b1);
        if (exp_addr_q.size() == 0) chk("unexpected_issue", rd_addr, 64'hdead);
        else chk("rd_addr", rd_addr, exp_addr_q.pop_front());
        outstanding++;
        tot_issues++;
      end
      if (held_v) chk("stall_stable", {m_valid, m_last, m_data}, {1'b1, held});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("stale_beat", {m_last, m_data}, 64'hdead);
        else chk("beat", {m_last, m_data}, exp_q.pop_front());
        hs_edge[tot_beats] = cyc + 1;
        tot_beats++;
        outstanding--;
        last_word = m_data;
        held_v    = 1'b0;
      end else if (m_valid) begin
        held_v = 1'b1;
        held   = {m_last, m_data};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int addr, input int len);
    logic ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = (AW + 1)'(len);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("cmd_accept", ok, 1'b1);
  endtask

  task automatic wait_done(input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && exp_addr_q.size() == 0 && !busy) done = 1'b1;
    end
    chk({"timeout_", name}, done, 1'b1);
    if (!done) begin
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_rd_en"},     rd_en,     1'b0);
    chk({tag, "_rd_addr"},   rd_addr,   '0);
    chk({tag, "_m_valid"},   m_valid,   1'b0);
    chk({tag, "_m_data"},    m_data,    '0);
    chk({tag, "_m_last"},    m_last,    1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int addr;
    int len;
    int pct;
    int stall;
    int exp_beats;
    int exp_last;
    int exp_issues;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int   base_beats;
    int   base_iss;
    logic seen;

    vecs[0] = '{5,  4,  100, 0,  4,  24,  0};  // basic burst
    vecs[1] = '{62, 4,  100, 0,  4,  3,   0};  // address wrap
    vecs[2] = '{0,  0,  100, 0,  0,  0,   0};  // zero length no-op
    vecs[3] = '{10, 64, 100, 0,  64, 27,  0};  // max length, wraps to 9
    vecs[4] = '{0,  32, 100, 0,  32, 93,  0};  // throughput
    vecs[5] = '{0,  64, 50,  30, 64, 189, 8};  // stall then random backpressure
    vecs[6] = '{33, 1,  70,  0,  1,  99,  0};  // single beat

    for (int i = 0; i < 64; i++) ram[i] = DW'(i * 3);
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[k]) begin
      ready_pct = (vecs[k].stall > 0) ? 0 : vecs[k].pct;
      @(posedge clk);
      #2;
      base_beats = tot_beats;
      base_iss   = tot_issues;
      send_cmd(vecs[k].addr, vecs[k].len);
      if (vecs[k].stall > 0) begin
        repeat (vecs[k].stall) @(posedge clk);
        #2;
        chk("stall_issues", tot_issues - base_iss, vecs[k].exp_issues);
        ready_pct = vecs[k].pct;
      end
      if (vecs[k].len == 0) begin
        seen = 1'b0;
        repeat (10) begin
          @(posedge clk);
          #2;
          seen = seen | m_valid | !cmd_ready | busy;
        end
        chk("zero_len_quiet", seen, 1'b0);
      end
      wait_done(3000, "burst");
      chk("beat_count", tot_beats - base_beats, vecs[k].exp_beats);
      if (vecs[k].exp_beats > 0) chk("last_word", last_word, vecs[k].exp_last);
      if (vecs[k].pct == 100 && vecs[k].len > 0 && tot_beats - base_beats == vecs[k].len) begin
        chk("first_latency", hs_edge[base_beats] - acc_edge, 6);
        chk("no_bubbles", hs_edge[base_beats + vecs[k].len - 1] - hs_edge[base_beats],
            vecs[k].len - 1);
      end
      @(posedge clk);
      #2;
      chk("idle_after", {busy, m_valid, cmd_ready}, 3'b001);
    end

    // reset in the middle of a burst, then a clean short burst
    ready_pct = 100;
    base_iss  = tot_issues;
    send_cmd(40, 16);
    for (int i = 0; i < 50 && (tot_issues - base_iss) < 3; i++) begin
      @(posedge clk);
      #2;
    end
    chk("mid_issues", tot_issues - base_iss, 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #2;
      seen = seen | m_valid | busy;
    end
    chk("no_stale_after_reset", seen, 1'b0);
    base_beats = tot_beats;
    send_cmd(20, 2);
    wait_done(200, "post_reset");
    chk("post_reset_beats", tot_beats - base_beats, 2);
    chk("post_reset_last", last_word, 63);

    // randomized bursts against the queue reference
    for (int n = 0; n < 12; n++) begin
      int addr;
      int len;
      int r;
      for (int i = 0; i < 64; i++) ram[i] = $urandom;
      addr = $urandom_range(0, 63);
      r    = $urandom_range(0, 9);
      len  = (r == 0) ? 0 : (r == 1) ? 64 : $urandom_range(1, 63);
      ready_pct = $urandom_range(20, 100);
      base_beats = tot_beats;
      send_cmd(addr, len);
      wait_done(3000, "random");
      chk("rand_beat_count", tot_beats - base_beats, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
